// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Optional MULDIV_FASTPATH_EN: trivial operands (zero, divide-by-zero, signed overflow) bypass iteration.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            valid,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(XLEN);

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [4:0]        rd_q, rd_d;
    logic              sa_q, sa_d;
    logic              sb_q, sb_d;
    logic [XLEN-1:0]   a_mag_q, a_mag_d;
    logic [XLEN-1:0]   b_mag_q, b_mag_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [4:0]        rd_out_q, rd_out_d;

    // Operand decode on the request inputs
    logic              sa_en, sb_en, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag_in, b_mag_in;
`ifdef MULDIV_FASTPATH_EN
    logic              fast;
`endif

    // Iteration datapath
    logic [XLEN:0]     mul_sum;
    logic [XLEN-1:0]   mul_hi, mul_lo;
    logic [XLEN:0]     rem_sh;
    logic              div_ge;
    logic [XLEN-1:0]   rem_sub;
    logic [XLEN-1:0]   div_hi, div_lo;

    // Final sign correction
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, a_orig, fin;

    always_comb begin
        sa_en    = op[2] ? !op[0] : (op[1:0] != 2'b11);
        sb_en    = op[2] ? !op[0] : (op[1:0] <= 2'b01);
        a_neg    = sa_en & a[XLEN-1];
        b_neg    = sb_en & b[XLEN-1];
        a_mag_in = a_neg ? -a : a;
        b_mag_in = b_neg ? -b : b;
`ifdef MULDIV_FASTPATH_EN
        fast = (a == '0) || (b == '0) ||
               (op[2] && !op[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1));
`endif
    end

    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_mag_q} : '0);
        mul_hi  = mul_sum[XLEN:1];
        mul_lo  = {mul_sum[0], lo_q[XLEN-1:1]};

        rem_sh  = {hi_q, lo_q[XLEN-1]};
        div_ge  = rem_sh >= {1'b0, b_mag_q};
        // When div_ge holds the true difference is below b_mag_q, so XLEN bits suffice
        rem_sub = rem_sh[XLEN-1:0] - b_mag_q;
        div_hi  = div_ge ? rem_sub : rem_sh[XLEN-1:0];
        div_lo  = {lo_q[XLEN-2:0], div_ge};
    end

    always_comb begin
        prod   = {hi_q, lo_q};
        prod_s = (sa_q ^ sb_q) ? -prod : prod;
        quo_s  = (sa_q ^ sb_q) ? -lo_q : lo_q;
        rem_s  = sa_q ? -hi_q : hi_q;
        a_orig = sa_q ? -a_mag_q : a_mag_q;
        if (op_q[2]) begin
            if (b_mag_q == '0) fin = op_q[1] ? a_orig : '1;
            else               fin = op_q[1] ? rem_s : quo_s;
        end else begin
            fin = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        a_mag_d  = a_mag_q;
        b_mag_d  = b_mag_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        result_d = result_q;
        rd_out_d = rd_out_q;

        case (state_q)
            S_IDLE: begin
                if (start && !kill) begin
                    state_d = S_CALC;
                    op_d    = op;
                    rd_d    = rd_in;
                    sa_d    = a_neg;
                    sb_d    = b_neg;
                    a_mag_d = a_mag_in;
                    b_mag_d = b_mag_in;
                    hi_d    = '0;
                    lo_d    = op[2] ? a_mag_in : b_mag_in;
                    cnt_d   = '0;
`ifdef MULDIV_FASTPATH_EN
                    // Preloading hi/lo with the finished magnitudes lets the shared
                    // sign-correction step produce the result on the very next edge.
                    if (fast) begin
                        cnt_d = CNT_MAX;
                        if (!op[2]) lo_d = '0;
                    end
`endif
                end
            end
            S_CALC: begin
                if (kill) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    res_d   = fin;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    hi_d  = op_q[2] ? div_hi : mul_hi;
                    lo_d  = op_q[2] ? div_lo : mul_lo;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (!kill) begin
                    result_d = res_q;
                    rd_out_d = rd_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            rd_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            a_mag_q  <= '0;
            b_mag_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            a_mag_q  <= a_mag_d;
            b_mag_q  <= b_mag_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
        end
    end

    // A kill during DONE suppresses the write-back in the same cycle
    assign busy   = (state_q != S_IDLE);
    assign valid  = (state_q == S_DONE) && !kill;
    assign result = valid ? res_q : result_q;
    assign rd_out = valid ? rd_q : rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M vectors, randomized ops against
// a 64-bit arithmetic reference, kill/start-while-busy handling and asynchronous reset.
module tb_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        kill;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd_in;
    logic        busy;
    logic        valid;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int          checks;
    int          failures;
    logic [31:0] last_result;
    logic [4:0]  last_rd;

    muldiv_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .kill   (kill),
        .op     (op),
        .a      (a),
        .b      (b),
        .rd_in  (rd_in),
        .busy   (busy),
        .valid  (valid),
        .result (result),
        .rd_out (rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] x,
                                               input logic [31:0] y);
        longint      sx, sy, ux, uy;
        logic [63:0] t;
        logic        ovf;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        ux  = longint'({32'd0, x});
        uy  = longint'({32'd0, y});
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        case (o)
            3'd0: begin t = sx * sy; return t[31:0];  end
            3'd1: begin t = sx * sy; return t[63:32]; end
            3'd2: begin t = sx * uy; return t[63:32]; end
            3'd3: begin t = ux * uy; return t[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                t = sx / sy; return t[31:0];
            end
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 0) return x;
                if (ovf) return 32'd0;
                t = sx % sy; return t[31:0];
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] o, input logic [31:0] x,
                                       input logic [31:0] y);
`ifdef MULDIV_FASTPATH_EN
        if (x == 0 || y == 0) return 1;
        if ((o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
`endif
        return 33;
    endfunction

    // Issue one op from IDLE (called #1 after an edge), wait for write-back and check it.
    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [4:0] r, input logic [31:0] expv, input string name);
        int n;
        int lat;
        lat   = exp_latency(o, x, y);
        op    = o;
        a     = x;
        b     = y;
        rd_in = r;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        rd_in = 5'($urandom);
        op    = 3'($urandom);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL %s busy_after_accept: got %b expected 1", name, busy);
        end
        n = 0;
        while (valid !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 200) begin
            failures++;
            $display("FAIL %s valid_timeout: got no valid expected valid after %0d edges", name, lat);
        end else begin
            checks++;
            if (n != lat) begin
                failures++;
                $display("FAIL %s latency: got %0d expected %0d", name, n, lat);
            end
            checks++;
            if (result !== expv) begin
                failures++;
                $display("FAIL %s result: got %h expected %h (op=%0d a=%h b=%h)", name, result, expv, o, x, y);
            end
            checks++;
            if (rd_out !== r) begin
                failures++;
                $display("FAIL %s rd_out: got %0d expected %0d", name, rd_out, r);
            end
            @(posedge clk); #1;
            checks++;
            if (valid !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL %s after_done: got valid=%b busy=%b expected valid=0 busy=0", name, valid, busy);
            end
            checks++;
            if (result !== expv || rd_out !== r) begin
                failures++;
                $display("FAIL %s hold: got %h/%0d expected %h/%0d", name, result, rd_out, expv, r);
            end
        end
        last_result = expv;
        last_rd     = r;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        kill  = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        rd_in = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || result !== 32'd0 || rd_out !== 5'd0) begin
            failures++;
            $display("FAIL reset_state: got busy=%b valid=%b result=%h rd_out=%0d expected all 0",
                     busy, valid, result, rd_out);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        last_result = '0;
        last_rd     = '0;
    endtask

    task automatic test_directed;
        do_op(3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, "mul_neg");
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, "mulhu_max");
        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'h0000_0000, "mulh_m1");
        do_op(3'd2, 32'hFFFF_FFFF, 32'd2,         5'd8,  32'hFFFF_FFFF, "mulhsu");
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFD, "div_neg");
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFF, "rem_neg");
        do_op(3'd5, 32'd100,        32'd7,         5'd11, 32'd14,        "divu");
        do_op(3'd7, 32'd100,        32'd7,         5'd12, 32'd2,         "remu");
        do_op(3'd5, 32'd100,        32'd0,         5'd13, 32'hFFFF_FFFF, "divu_zero");
        do_op(3'd7, 32'd100,        32'd0,         5'd14, 32'h0000_0064, "remu_zero");
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, "div_ovf");
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0,  32'h0000_0000, "rem_ovf");
        do_op(3'd6, 32'hFFFF_FFF0, 32'd0,         5'd16, 32'hFFFF_FFF0, "rem_zero_neg");
        do_op(3'd1, 32'd0,          32'h8000_0000, 5'd17, 32'h0000_0000, "mulh_zero");
    endtask

    task automatic test_random;
        logic [31:0] pool [5];
        logic [31:0] x, y;
        logic [2:0]  o;
        logic [4:0]  r;
        pool[0] = 32'h0;
        pool[1] = 32'h1;
        pool[2] = 32'hFFFF_FFFF;
        pool[3] = 32'h8000_0000;
        pool[4] = 32'h7FFF_FFFF;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            x = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 4)] : $urandom;
            y = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 4)] : $urandom;
            if ($urandom_range(0, 3) == 0) y = y >> $urandom_range(1, 31);
            r = 5'($urandom);
            do_op(o, x, y, r, ref_model(o, x, y), "random");
        end
    endtask

    task automatic test_back_to_back;
        do_op(3'd0, 32'd1234,       32'd5678,      5'd20, ref_model(3'd0, 32'd1234, 32'd5678), "b2b_first");
        do_op(3'd5, 32'hDEAD_BEEF, 32'd3,         5'd21, ref_model(3'd5, 32'hDEAD_BEEF, 32'd3), "b2b_second");
        do_op(3'd6, 32'h8765_4321, 32'd1000,      5'd22, ref_model(3'd6, 32'h8765_4321, 32'd1000), "b2b_third");
    endtask

    task automatic test_ignore_start;
        int vcount;
        int vn;
        logic [31:0] vres;
        vcount = 0;
        vn     = 0;
        vres   = '0;
        op     = 3'd0;
        a      = 32'd5;
        b      = 32'd6;
        rd_in  = 5'd4;
        start  = 1'b1;
        @(posedge clk); #1;
        op    = 3'd5;
        a     = 32'd99;
        b     = 32'd9;
        rd_in = 5'd30;
        for (int n = 1; n <= 70; n++) begin
            @(posedge clk); #1;
            if (n == 20) start = 1'b0;
            if (valid === 1'b1) begin
                vcount++;
                vn   = n;
                vres = result;
            end
        end
        checks++;
        if (vcount != 1) begin
            failures++;
            $display("FAIL ignore_start_count: got %0d valid pulses expected 1", vcount);
        end
        checks++;
        if (vn != 33 || vres !== 32'd30) begin
            failures++;
            $display("FAIL ignore_start_result: got edge %0d result %h expected edge 33 result %h", vn, vres, 32'd30);
        end
        last_result = 32'd30;
        last_rd     = 5'd4;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL ignore_start_idle: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_kill;
        int n;
        int vcount;
        // kill in the 10th CALC cycle
        op    = 3'd0;
        a     = 32'd12345;
        b     = 32'd678;
        rd_in = 5'd9;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            failures++;
            $display("FAIL kill_calc: got busy=%b valid=%b expected 0/0", busy, valid);
        end
        vcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (valid === 1'b1) vcount++;
        end
        checks++;
        if (vcount != 0 || result !== last_result || rd_out !== last_rd) begin
            failures++;
            $display("FAIL kill_calc_hold: got %0d valids result=%h rd=%0d expected 0 valids result=%h rd=%0d",
                     vcount, result, rd_out, last_result, last_rd);
        end

        // kill coinciding with the DONE cycle
        op    = 3'd5;
        a     = 32'd1000;
        b     = 32'd10;
        rd_in = 5'd3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (valid !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 200) begin
            failures++;
            $display("FAIL kill_done_timeout: got no valid expected valid");
        end
        kill = 1'b1;
        #1;
        checks++;
        if (valid !== 1'b0 || result !== last_result || rd_out !== last_rd) begin
            failures++;
            $display("FAIL kill_done_mask: got valid=%b result=%h rd=%0d expected 0/%h/%0d",
                     valid, result, rd_out, last_result, last_rd);
        end
        @(posedge clk); #1;
        kill = 1'b0;
        checks++;
        if (busy !== 1'b0 || result !== last_result || rd_out !== last_rd) begin
            failures++;
            $display("FAIL kill_done_after: got busy=%b result=%h rd=%0d expected 0/%h/%0d",
                     busy, result, rd_out, last_result, last_rd);
        end

        // kill and start together in IDLE
        op    = 3'd0;
        a     = 32'd2;
        b     = 32'd3;
        rd_in = 5'd1;
        start = 1'b1;
        kill  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        kill  = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL kill_start_idle: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid;
        op    = 3'd0;
        a     = 32'h1234;
        b     = 32'h55;
        rd_in = 5'd7;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || result !== 32'd0 || rd_out !== 5'd0) begin
            failures++;
            $display("FAIL reset_mid: got busy=%b valid=%b result=%h rd_out=%0d expected all 0",
                     busy, valid, result, rd_out);
        end
        @(posedge clk); #1;
        rst_n       = 1'b1;
        last_result = '0;
        last_rd     = '0;
        @(posedge clk); #1;
        do_op(3'd0, 32'd3, 32'd4, 5'd2, 32'd12, "mul_after_reset");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_ignore_start();
        test_kill();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
